// File: rtl/branch_cond_unit.sv
// Two-stage branch-condition evaluator: captures the condition field and operand on con_in,
// then registers the branch flag. Define BRCOND_STATS_EN to build the saturating taken-branch counter.
module branch_cond_unit #(
  parameter int DATA_W   = 32,
  parameter int COND_LSB = 19,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] bus,
  input  logic              con_in,
  output logic              con_q,
  output logic              con_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count
);

  function automatic logic eval_cond(input logic [2:0] code, input logic [DATA_W-1:0] val);
    logic z;
    logic n;
    logic r;
    z = (val == {DATA_W{1'b0}});
    n = val[DATA_W-1];
    case (code)
      3'b000:  r = z;
      3'b001:  r = ~z;
      3'b010:  r = ~n;
      3'b011:  r = n;
      3'b100:  r = 1'b1;
      3'b101:  r = 1'b0;
      3'b110:  r = ~n & ~z;
      3'b111:  r = n | z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [2:0]        s1_code_q, s1_code_d;
  logic [DATA_W-1:0] s1_val_q, s1_val_d;
  logic              s1_v_q, s1_v_d;
  logic              con_q_q, con_q_d;
  logic              con_valid_q, con_valid_d;
  logic              result_s;
  logic              unused_ir_s;

  // Only the condition field of ir is consumed.
  assign unused_ir_s = ^ir;
  assign result_s    = eval_cond(s1_code_q, s1_val_q);

  // Next-state logic for both pipeline stages
  always_comb begin
    s1_v_d      = con_in;
    s1_code_d   = s1_code_q;
    s1_val_d    = s1_val_q;
    con_valid_d = s1_v_q;
    con_q_d     = con_q_q;
    if (con_in) begin
      s1_code_d = ir[COND_LSB +: 3];
      s1_val_d  = bus;
    end else begin
      s1_code_d = s1_code_q;
      s1_val_d  = s1_val_q;
    end
    if (s1_v_q) begin
      con_q_d = result_s;
    end else begin
      con_q_d = con_q_q;
    end
  end

  // Pipeline registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_code_q   <= 3'b000;
      s1_val_q    <= {DATA_W{1'b0}};
      s1_v_q      <= 1'b0;
      con_q_q     <= 1'b0;
      con_valid_q <= 1'b0;
    end else begin
      s1_code_q   <= s1_code_d;
      s1_val_q    <= s1_val_d;
      s1_v_q      <= s1_v_d;
      con_q_q     <= con_q_d;
      con_valid_q <= con_valid_d;
    end
  end

  assign con_q     = con_q_q;
  assign con_valid = con_valid_q;
  assign busy      = s1_v_q;

`ifdef BRCOND_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of taken results, advanced alongside the S2 update
  always_comb begin
    cnt_d = cnt_q;
    if (s1_v_q && result_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared only by clr
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_count = cnt_q;
`else
  assign taken_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit; expectations are hand-computed tables.
module tb_branch_cond_unit;

  localparam int DATA_W   = 32;
  localparam int COND_LSB = 19;
  localparam int CNT_W    = 2;

  logic              clk;
  logic              clr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] bus;
  logic              con_in;
  logic              con_q;
  logic              con_valid;
  logic              busy;
  logic [CNT_W-1:0]  taken_count;

  int vectors_applied = 0;
  int miscompares     = 0;

  branch_cond_unit #(.DATA_W(DATA_W), .COND_LSB(COND_LSB), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .ir(ir), .bus(bus), .con_in(con_in),
    .con_q(con_q), .con_valid(con_valid), .busy(busy), .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] code, input logic [31:0] val);
    logic [31:0] ir_v;
    ir_v = $urandom();
    ir_v[COND_LSB +: 3] = code;
    ir  = ir_v;
    bus = val;
    con_in = 1'b1;
  endtask

  // Issue one isolated request; called #1 after an edge, returns #1 after the result edge.
  task automatic req(input string tag, input logic [2:0] code, input logic [31:0] val, input logic exp);
    drive(code, val);
    @(posedge clk); #1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    con_in = 1'b0;
    bus = $urandom();
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, con_valid}, 32'd1);
    check({tag, "_flag"}, {31'd0, con_q}, {31'd0, exp});
    check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] leg_val [3]  = '{32'h0000_0000, 32'h0000_0005, 32'h8000_0000};
  logic [3:0]  leg_exp [3]  = '{4'b0101, 4'b0110, 4'b1010}; // bit k = expected flag for code k
  logic [3:0]  new_exp [2]  = '{4'b1001, 4'b0101};          // bit k = expected flag for code 4+k
  logic [2:0]  str_code [4] = '{3'b000, 3'b001, 3'b011, 3'b110};
  logic [31:0] str_val [4]  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
  logic [3:0]  str_exp      = 4'b0101;
  logic [CNT_W-1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    clr = 1'b1; con_in = 1'b1; bus = 32'd0; ir = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_con_q", {31'd0, con_q}, 32'd0);
      check("rst_valid", {31'd0, con_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_count", {30'd0, taken_count}, 32'd0);
    end
    clr = 1'b0;
    req("post_rst", 3'b000, 32'd0, 1'b1);

    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 4; c++) begin
        req($sformatf("leg_v%0d_c%0d", v, c), 3'(c), leg_val[v], leg_exp[v][c]);
      end
    end

    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < 4; c++) begin
        req($sformatf("new_v%0d_c%0d", v, 4 + c), 3'(4 + c), 32'(v), new_exp[v][c]);
      end
    end

    // Back-to-back stream: result i appears one edge after request i is sampled.
    for (int i = 0; i < 4; i++) begin
      drive(str_code[i], str_val[i]);
      @(posedge clk); #1;
      check($sformatf("str_busy%0d", i), {31'd0, busy}, 32'd1);
      if (i > 0) begin
        check($sformatf("str_valid%0d", i - 1), {31'd0, con_valid}, 32'd1);
        check($sformatf("str_flag%0d", i - 1), {31'd0, con_q}, {31'd0, str_exp[i - 1]});
      end
    end
    con_in = 1'b0;
    @(posedge clk); #1;
    check("str_valid3", {31'd0, con_valid}, 32'd1);
    check("str_flag3", {31'd0, con_q}, {31'd0, str_exp[3]});
    @(posedge clk); #1;
    check("str_idle", {31'd0, con_valid}, 32'd0);
    check("str_hold", {31'd0, con_q}, {31'd0, str_exp[3]});

    // Reset mid-flight, starting from a held flag of 1.
    req("pre_mid", 3'b100, 32'd0, 1'b1);
    drive(3'b100, 32'd7);
    @(posedge clk); #1;
    con_in = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("mid_valid", {31'd0, con_valid}, 32'd0);
    check("mid_con_q", {31'd0, con_q}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_count", {30'd0, taken_count}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("mid_nopulse", {31'd0, con_valid}, 32'd0);
      check("mid_con_q_hold", {31'd0, con_q}, 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      req($sformatf("cnt%0d", i), 3'b100, $urandom(), 1'b1);
`ifdef BRCOND_STATS_EN
      check($sformatf("cnt%0d_val", i), {30'd0, taken_count}, {30'd0, cnt_exp[i]});
`else
      check($sformatf("cnt%0d_val", i), {30'd0, taken_count}, 32'd0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
